// File: rtl/regfile_scoreboard.sv
// Dual-bank (GPR/FPR) register file with a per-register busy/countdown scoreboard for decode.
// Define RF_BYPASS_EN to forward same-cycle writeback data to the read ports.
module regfile_scoreboard #(
    parameter int              XLEN     = 32,
    parameter int              NREG     = 32,
    parameter int              NRD      = 3,
    parameter int              LW       = 5,
    parameter logic [XLEN-1:0] R28_INIT = 32'h000F4240,
    parameter logic [XLEN-1:0] R29_INIT = 32'h00000030,
    parameter int              AW       = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NRD*(AW+1)-1:0] rd_addr,
    output logic [NRD*XLEN-1:0]   rd_data,
    output logic [NRD-1:0]        rd_busy,
    output logic [NRD*LW-1:0]     rd_wait,
    input  logic                  iss_valid,
    input  logic                  iss_we,
    input  logic [AW:0]           iss_dst,
    input  logic [LW-1:0]         iss_lat,
    input  logic [NRD-1:0]        iss_src_en,
    output logic                  stall,
    input  logic                  wb_en,
    input  logic [AW:0]           wb_addr,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  flush
);
    localparam int A1 = AW + 1;
    localparam int NR = 2 * NREG;

    logic [XLEN-1:0] regs [NR];
    logic [NR-1:0]   busy;
    logic [LW-1:0]   cnt  [NR];
    logic            waw;
    logic            set_busy;

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW:0] a;
        logic        fwd;
        assign a = rd_addr[i*A1 +: A1];
`ifdef RF_BYPASS_EN
        assign fwd = wb_en && (wb_addr == a) && (a != '0);
`else
        assign fwd = 1'b0;
`endif
        // regs[0] is never written, so GPR[0] reads 0 without a special case
        assign rd_data[i*XLEN +: XLEN] = fwd ? wb_data : regs[a];
        assign rd_busy[i]              = busy[a] & ~fwd;
        assign rd_wait[i*LW +: LW]     = busy[a] ? cnt[a] : '0;
    end

    assign waw      = iss_we & busy[iss_dst] & ~(wb_en && (wb_addr == iss_dst));
    assign stall    = (|(rd_busy & iss_src_en)) | waw;
    assign set_busy = iss_valid & ~stall & iss_we & (iss_dst != '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int j = 0; j < NR; j++) begin
                regs[j] <= '0;
            end
            regs[28] <= R28_INIT;
            regs[29] <= R29_INIT;
        end else if (wb_en && (wb_addr != '0)) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Issue beats flush beats writeback; the countdown only runs on untouched busy entries.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy <= '0;
            for (int j = 0; j < NR; j++) begin
                cnt[j] <= '0;
            end
        end else begin
            for (int j = 0; j < NR; j++) begin
                if (set_busy && (iss_dst == A1'(j))) begin
                    busy[j] <= 1'b1;
                    cnt[j]  <= iss_lat;
                end else if (flush) begin
                    busy[j] <= 1'b0;
                    cnt[j]  <= '0;
                end else if (wb_en && (wb_addr == A1'(j))) begin
                    busy[j] <= 1'b0;
                    cnt[j]  <= '0;
                end else if (busy[j] && (cnt[j] != '0)) begin
                    cnt[j] <= cnt[j] - LW'(1);
                end
            end
        end
    end
endmodule
